// File: rtl/alu_operand_stage.sv
// Operand-issue stage feeding the ALU: regfile read with writeback bypass, pending-register
// scoreboard, output register plus one-entry skid. Optional counters: ALU_OPSTAGE_STATS_EN.
module alu_operand_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic [REG_AW-1:0]  in_ra,
  input  logic [REG_AW-1:0]  in_rb,
  input  logic [REG_AW-1:0]  in_rc,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_use_imm,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_opcode,
  output logic [DATA_W-1:0]  out_A,
  output logic [DATA_W-1:0]  out_B,
  output logic [DATA_W-1:0]  out_C,
  output logic [SHIFT_W-1:0] out_shift,
  output logic [REG_AW-1:0]  out_rd,
  output logic [15:0]        stat_issue,
  output logic [15:0]        stat_stall
);

  localparam int unsigned NREG = 1 << REG_AW;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  c;
    logic [SHIFT_W-1:0] shift;
    logic [REG_AW-1:0]  rd;
  } payload_t;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  payload_t          r_out;
  payload_t          r_skid;
  logic              r_out_valid;
  logic              r_skid_valid;

  logic [NREG-1:0]   w_wb_clr;
  logic [NREG-1:0]   w_rd_set;
  logic [NREG-1:0]   w_pend_eff;
  logic              w_hazard;
  logic              w_accept;
  logic              w_out_free;
  logic              w_handshake;
  payload_t          w_new;

  // r0 is hardwired zero; a same-cycle writeback overrides the stored value.
  function automatic logic [DATA_W-1:0] f_rd(input logic [REG_AW-1:0] addr,
                                             input logic [DATA_W-1:0] regval,
                                             input logic              bp_en,
                                             input logic [REG_AW-1:0] bp_addr,
                                             input logic [DATA_W-1:0] bp_data);
    if (addr == '0)                    return '0;
    else if (bp_en && bp_addr == addr) return bp_data;
    else                               return regval;
  endfunction

  always_comb begin
    w_wb_clr   = wb_en ? (NREG'(1) << wb_addr) : '0;
    w_pend_eff = r_pending & ~w_wb_clr;
    w_hazard   = w_pend_eff[in_ra] | w_pend_eff[in_rc] | (!in_use_imm & w_pend_eff[in_rb]);
    in_ready   = !rst & !r_skid_valid & !w_hazard;
    w_accept   = in_valid & in_ready;
    w_rd_set   = (w_accept && in_rd != '0) ? (NREG'(1) << in_rd) : '0;
    w_out_free = !r_out_valid | out_ready;
    w_handshake = r_out_valid & out_ready;

    w_new        = '0;
    w_new.opcode = in_opcode;
    w_new.a      = f_rd(in_ra, r_regs[in_ra], wb_en, wb_addr, wb_data);
    w_new.b      = in_use_imm ? in_imm : f_rd(in_rb, r_regs[in_rb], wb_en, wb_addr, wb_data);
    w_new.c      = f_rd(in_rc, r_regs[in_rc], wb_en, wb_addr, wb_data);
    w_new.shift  = in_shift;
    w_new.rd     = in_rd;
  end

  // Register file; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard: a new producer's set beats a same-cycle writeback clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_wb_clr) | w_rd_set;
  end

  // Output register with one-entry skid; skid always drains before new input is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_new;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_opcode = r_out.opcode;
  assign out_A      = r_out.a;
  assign out_B      = r_out.b;
  assign out_C      = r_out.c;
  assign out_shift  = r_out.shift;
  assign out_rd     = r_out.rd;

`ifdef ALU_OPSTAGE_STATS_EN
  logic [15:0] r_stat_issue;
  logic [15:0] r_stat_stall;

  // Saturating issue / hazard-stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_issue <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_handshake && r_stat_issue != 16'hFFFF) r_stat_issue <= r_stat_issue + 16'd1;
      if (in_valid && w_hazard && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_issue = r_stat_issue;
  assign stat_stall = r_stat_stall;
`else
  assign stat_issue = 16'h0000;
  assign stat_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: bypass, hazards, skid ordering, imm select, reset.
module tb_alu_operand_stage;

`ifdef ALU_OPSTAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [5:0] ALU_ADD = 6'h01;

  logic        clk, rst;
  logic        in_valid, in_ready, in_use_imm, wb_en, out_valid, out_ready;
  logic [5:0]  in_opcode, out_opcode;
  logic [3:0]  in_ra, in_rb, in_rc, in_rd, wb_addr, out_rd;
  logic [15:0] in_imm, wb_data, out_A, out_B, out_C, stat_issue, stat_stall;
  logic [4:0]  in_shift, out_shift;

  int checks   = 0;
  int failures = 0;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_shift(in_shift),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_shift(out_shift), .out_rd(out_rd),
    .stat_issue(stat_issue), .stat_stall(stat_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic [3:0] rd);
    in_valid = 1'b1; in_opcode = op; in_ra = ra; in_rb = rb; in_rc = rc; in_rd = rd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_ra = '0; in_rb = '0; in_rc = '0;
    in_rd = '0; in_use_imm = 1'b0; in_imm = '0; in_shift = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_A", 32'(out_A), 32'd0);
    chk("rst_stat_issue", 32'(stat_issue), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: writeback then read
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    issue(ALU_ADD, 4'd3, 4'd0, 4'd0, 4'd0); in_shift = 5'd4;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_A", 32'(out_A), 32'h1234);
    chk("t1_out_B", 32'(out_B), 32'h0);
    chk("t1_out_opcode", 32'(out_opcode), 32'(ALU_ADD));
    chk("t1_out_shift", 32'(out_shift), 32'd4);

    // 2: same-cycle writeback bypass
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'h00FF;
    issue(6'd2, 4'd5, 4'd0, 4'd3, 4'd0);
    #1 chk("t2_in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("t2_out_A_bypass", 32'(out_A), 32'h00FF);
    chk("t2_out_C", 32'(out_C), 32'h1234);

    // 3: RAW hazard on r7 for three cycles, released by writeback
    issue(6'd3, 4'd0, 4'd0, 4'd0, 4'd7);
    tick();
    issue(6'd4, 4'd7, 4'd0, 4'd0, 4'd0);
    #1 chk("t3_out_rd", 32'(out_rd), 32'd7);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF;
    #1 chk("t3_wb_in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("t3_out_A", 32'(out_A), 32'hBEEF);
    chk("t3_out_opcode", 32'(out_opcode), 32'd4);
    chk("t3_stat_stall", 32'(stat_stall), STATS ? 32'd3 : 32'd0);
    chk("t3_stat_issue", 32'(stat_issue), STATS ? 32'd3 : 32'd0);

    // same-cycle set and clear of r8: set wins
    issue(6'd5, 4'd0, 4'd0, 4'd0, 4'd8);
    wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h1111;
    tick();
    wb_en = 1'b0;
    issue(6'd6, 4'd8, 4'd0, 4'd0, 4'd0);
    #1 chk("set_wins_in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h2222;
    #1 chk("set_wins_release", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("set_wins_out_A", 32'(out_A), 32'h2222);

    // 5: immediate operand ignores pending rb
    issue(6'd7, 4'd0, 4'd0, 4'd0, 4'd9);
    tick();
    issue(6'd8, 4'd0, 4'd9, 4'd0, 4'd0);
    #1 chk("t5_rb_hazard", 32'(in_ready), 32'd0);
    in_use_imm = 1'b1; in_imm = 16'hFF80;
    #1 chk("t5_imm_no_stall", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_use_imm = 1'b0;
    chk("t5_out_B", 32'(out_B), 32'hFF80);
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h0009;
    tick();
    wb_en = 1'b0;

    // 4: backpressure into skid, then in-order drain
    out_ready = 1'b0;
    issue(6'd10, 4'd3, 4'd0, 4'd0, 4'd0);
    tick();
    chk("t4_i1_out", 32'(out_opcode), 32'd10);
    issue(6'd11, 4'd5, 4'd0, 4'd0, 4'd0);
    #1 chk("t4_i2_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t4_hold_opcode", 32'(out_opcode), 32'd10);
    chk("t4_hold_A", 32'(out_A), 32'h1234);
    chk("t4_skid_full", 32'(in_ready), 32'd0);
    issue(6'd12, 4'd8, 4'd0, 4'd0, 4'd0);
    tick();
    chk("t4_i3_held", 32'(out_opcode), 32'd10);
    chk("t4_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t4_i2_out", 32'(out_opcode), 32'd11);
    chk("t4_i2_A", 32'(out_A), 32'h00FF);
    chk("t4_i2_valid", 32'(out_valid), 32'd1);
    chk("t4_drained_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_i3_out", 32'(out_opcode), 32'd12);
    chk("t4_i3_A", 32'(out_A), 32'h2222);
    tick();
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_stat_issue", 32'(stat_issue), STATS ? 32'd11 : 32'd0);
    chk("t4_stat_stall", 32'(stat_stall), STATS ? 32'd4 : 32'd0);

    // 6: asynchronous reset mid-operation
    out_ready = 1'b0;
    issue(6'd13, 4'd0, 4'd0, 4'd0, 4'd7);
    tick();
    issue(6'd14, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_opcode", 32'(out_opcode), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_stat", 32'(stat_issue), 32'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    issue(6'd15, 4'd7, 4'd3, 4'd8, 4'd0);
    #1 chk("t6_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_opcode", 32'(out_opcode), 32'd15);
    chk("t6_out_A", 32'(out_A), 32'd0);
    chk("t6_out_B", 32'(out_B), 32'd0);
    chk("t6_out_C", 32'(out_C), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
